// File: rtl/reflector_loader.sv
// ---------------------------------------------------------------------------
// reflector_loader
//
// Purpose:
//   Streams a 26-letter reflector wiring table in byte by byte, checks each
//   byte for a legal upper-case letter and for duplicates, and then walks the
//   finished table to confirm it is a fixed-point-free involution. Only a
//   table that passes every check is copied to idx_out, with a one-cycle set
//   strobe. A rejected load leaves the previously committed table in place
//   and reports why it failed.
//
// Ports:
//   clk        in   1    clock
//   reset_n    in   1    asynchronous active-low reset
//   start      in   1    begin a new table load (honoured in IDLE only)
//   in_valid   in   1    in_data carries a wiring byte
//   in_data    in   8    ASCII letter for the current table position
//   in_ready   out  1    a byte is accepted this cycle when in_valid is high
//   idx_out    out  208  committed table, entry i at [207-8i:200-8i]
//   set        out  1    one-cycle strobe when idx_out is updated
//   busy       out  1    high whenever the loader is not idle
//   done       out  1    one-cycle strobe at the end of every load
//   error      out  1    last load was rejected; held until the next start
//   err_code   out  2    01 bad char, 10 duplicate, 11 not a valid reflector
// ---------------------------------------------------------------------------
module reflector_loader (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [207:0] idx_out,
    output logic         set,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    localparam logic [1:0] ERR_CHAR = 2'b01;
    localparam logic [1:0] ERR_DUP  = 2'b10;
    localparam logic [1:0] ERR_REFL = 2'b11;

    logic [2:0]   r_state;
    logic [4:0]   r_pos;          // load position in LOAD, check index in CHECK
    logic [25:0]  r_used;         // one bit per letter already seen
    logic [7:0]   r_shadow [26];  // table under construction
    logic [207:0] r_idx;
    logic         r_set;
    logic         r_done;
    logic         r_error;
    logic [1:0]   r_err_code;
    logic [1:0]   r_pend_code;    // reason captured at rejection, published in FAIL

    logic         w_letter;
    logic [4:0]   w_in_off;
    logic [4:0]   w_chk_j;
    logic         w_chk_bad;
    logic [207:0] w_shadow_packed;

    // 'A'..'Z' are 0x41..0x5A, so the low five bits minus one give 0..25
    // without needing the upper bits of a full 8-bit subtraction.
    assign w_letter = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign w_in_off = in_data[4:0] - 5'd1;

    // Involution check for entry i = r_pos: partner j must map back to i,
    // and j == i would be a letter wired to itself.
    assign w_chk_j   = r_shadow[r_pos][4:0] - 5'd1;
    assign w_chk_bad = (r_shadow[w_chk_j] != (8'h41 + {3'b000, r_pos}))
                    || (w_chk_j == r_pos);

    genvar gi;
    generate
        for (gi = 0; gi < 26; gi++) begin : g_pack
            assign w_shadow_packed[207-8*gi -: 8] = r_shadow[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pos       <= 5'd0;
            r_used      <= 26'd0;
            for (int k = 0; k < 26; k++) begin
                r_shadow[k] <= 8'h00;
            end
            r_idx       <= 208'd0;
            r_set       <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= 2'b00;
            r_pend_code <= 2'b00;
        end else begin
            // Strobes default low so they can never last two cycles.
            r_set  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_pos      <= 5'd0;
                        r_used     <= 26'd0;
                        r_error    <= 1'b0;
                        r_err_code <= 2'b00;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (!w_letter) begin
                            r_pend_code <= ERR_CHAR;
                            r_state     <= S_FAIL;
                        end else if (r_used[w_in_off]) begin
                            r_pend_code <= ERR_DUP;
                            r_state     <= S_FAIL;
                        end else begin
                            r_shadow[r_pos]  <= in_data;
                            r_used[w_in_off] <= 1'b1;
                            if (r_pos == 5'd25) begin
                                r_pos   <= 5'd0;
                                r_state <= S_CHECK;
                            end else begin
                                r_pos <= r_pos + 5'd1;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (w_chk_bad) begin
                        r_pend_code <= ERR_REFL;
                        r_state     <= S_FAIL;
                    end else if (r_pos == 5'd25) begin
                        r_pos   <= 5'd0;
                        r_state <= S_COMMIT;
                    end else begin
                        r_pos <= r_pos + 5'd1;
                    end
                end
                S_COMMIT: begin
                    r_idx   <= w_shadow_packed;
                    r_set   <= 1'b1;
                    r_done  <= 1'b1;
                    r_error <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    r_error    <= 1'b1;
                    r_err_code <= r_pend_code;
                    r_done     <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = (r_state == S_LOAD);
    assign busy     = (r_state != S_IDLE);
    assign idx_out  = r_idx;
    assign set      = r_set;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_reflector_loader.sv
// ---------------------------------------------------------------------------
// tb_reflector_loader
//
// Purpose:
//   Self-checking bench for reflector_loader. A table of load records is
//   applied in a loop; each start pushes its expected outcome to a queue which
//   is popped and compared when done pulses. Hand-written sequences cover the
//   reset state and a reset in the middle of a load.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_reflector_loader;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [207:0] idx_out;
    logic         set;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   err_code;

    reflector_loader dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .idx_out  (idx_out),
        .set      (set),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [207:0] data;      // 26 bytes, position 0 in the top byte
        bit           gaps;      // randomise in_valid
        bit           inj_start; // toggle start while busy
        logic         exp_err;
        logic [1:0]   exp_code;
        int           exp_lat;   // -1: do not check latency
    } vec_t;

    typedef struct {
        logic         exp_set;
        logic         exp_err;
        logic [1:0]   exp_code;
        logic [207:0] exp_idx;
        int           exp_lat;
    } exp_t;

    localparam logic [207:0] UKW_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    localparam logic [207:0] UKW_C = "FVPJIAOYEDRZXWGCTKUQSBNMHL";

    int           n_checks;
    int           n_fail;
    exp_t         exp_q[$];
    logic [207:0] model_idx;
    vec_t         vecs[7];

    task automatic check(input string name, input logic [207:0] act, input logic [207:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_idx_out"}, idx_out, 208'd0);
        check({tag, "_set"}, set, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    task automatic run_load(input vec_t v, input int id);
        exp_t e;
        int   pos;
        int   cyc;
        int   cnt;
        e.exp_err  = v.exp_err;
        e.exp_code = v.exp_err ? v.exp_code : 2'b00;
        e.exp_set  = !v.exp_err;
        e.exp_idx  = v.exp_err ? model_idx : v.data;
        e.exp_lat  = v.exp_lat;
        if (!v.exp_err) model_idx = v.data;
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        check("busy_after_start", busy, 1);

        pos = 0;
        while (pos < 26) begin
            if (!in_ready) break;
            in_valid = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? v.data[207-8*pos -: 8] : 8'h3F;
            if (v.inj_start) start = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (in_valid) pos++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        check("in_ready_low_after_last", in_ready, 0);

        cnt = 0;
        while (!done && cnt < 200) begin
            start = v.inj_start ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            cyc++;
            cnt++;
        end
        start = 1'b0;

        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout load %0d: no done within 200 cycles", id);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        check("set_at_done", set, e.exp_set);
        check("error_at_done", error, e.exp_err);
        check("err_code_at_done", err_code, e.exp_code);
        check("idx_out_at_done", idx_out, e.exp_idx);
        check("busy_at_done", busy, 0);
        if (e.exp_lat >= 0) check("latency", cyc, e.exp_lat);

        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("set_one_cycle", set, 0);
        check("error_held", error, e.exp_err);
        check("idx_out_held", idx_out, e.exp_idx);
        $display("load %0d: error=%0d err_code=%0d set=%0d latency=%0d", id, e.exp_err, e.exp_code, e.exp_set, cyc);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_idx = 208'd0;
        reset_n   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;

        // {data, gaps, inj_start, exp_err, exp_code, exp_lat}
        vecs[0] = '{UKW_B, 1'b0, 1'b0, 1'b0, 2'b00, 53};
        vecs[1] = '{"YRUHQaLDPXNGOKMIEBFZCWVJAT", 1'b0, 1'b0, 1'b1, 2'b01, 7};
        vecs[2] = '{"AABCDEFGHIJKLMNOPQRSTUVWXY", 1'b0, 1'b0, 1'b1, 2'b10, 3};
        vecs[3] = '{"BCDEFGHIJKLMNOPQRSTUVWXYZA", 1'b0, 1'b0, 1'b1, 2'b11, 28};
        vecs[4] = '{"ACBEDGFIHKJMLONQPSRUTWVYXZ", 1'b0, 1'b0, 1'b1, 2'b11, 28};
        vecs[5] = '{UKW_C, 1'b0, 1'b0, 1'b0, 2'b00, 53};
        vecs[6] = '{UKW_B, 1'b1, 1'b1, 1'b0, 2'b00, -1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i], i);
        end
        check("ukw_b_first_byte", idx_out[207:200], 8'h59);
        check("ukw_b_last_byte", idx_out[7:0], 8'h54);

        // Leave error set, then reset ten bytes into a fresh load.
        run_load(vecs[1], 7);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        for (int p = 0; p < 10; p++) begin
            in_data = UKW_B[207-8*p -: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("busy_mid_load", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check_zero("mid_load_reset");
        model_idx = 208'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        $display("mid-load reset applied after 10 accepted bytes");

        run_load(vecs[0], 8);
        check("final_idx", idx_out, UKW_B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reflector_loader.md
REFLECTOR_LOADER -- requirements
Module: reflector_loader

Interface
REQ-001 The block SHALL use reset reset_n, asynchronous, active-low; clock clk.
REQ-002 Ports, one per line: name  direction  width  meaning:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- start  in  1  begin new table load; sampled in IDLE only
- in_valid  in  1  in_data holds a wiring byte
- in_data  in  8  ASCII letter for current table position
- in_ready  out  1  block accepts byte this cycle
- idx_out  out  208  committed reflector table; drives reflector idx_in
- set  out  1  one-cycle strobe to reflector set input
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle strobe on load completion, pass or fail
- error  out  1  last load rejected; held until next accepted start
- err_code  out  2  01 bad char, 10 duplicate, 11 not a valid reflector

Function
REQ-003 The block SHALL pack table entry i (i=0 for 'A') at idx_out[207-8i:200-8i].
REQ-004 The block SHALL implement FSM states IDLE, LOAD, CHECK, COMMIT, FAIL.
REQ-005 IDLE: in_ready=0; start=1 -> LOAD next cycle; clears position counter, 26-bit used bitmap, error, err_code.
REQ-006 start SHALL be ignored in every state except IDLE.
REQ-007 LOAD: in_ready=1; a byte is accepted only on in_valid & in_ready; gaps in in_valid stall without timeout.
REQ-008 Accepted byte outside 8'h41..8'h5A -> FAIL, err_code=01; byte not stored.
REQ-009 Accepted byte whose bitmap bit is set -> FAIL, err_code=10.
REQ-010 Otherwise store byte in shadow table at counter position, set bitmap bit, increment counter; on the 26th accepted byte -> CHECK, counter cleared.
REQ-011 in_ready SHALL be 0 in the cycle following the 26th accept or any rejected byte.
REQ-012 CHECK: one entry per cycle, i=0..25: j=shadow[i]-65; fail if shadow[j] != 8'h41+i (not an involution) or j==i (fixed point) -> FAIL, err_code=11; first failing i terminates CHECK.
REQ-013 After i=25 passes -> COMMIT.
REQ-014 COMMIT: idx_out <= shadow table, set=1 and done=1 for exactly this cycle, error=0; -> IDLE.
REQ-015 FAIL: error=1, err_code latched, done=1 for one cycle, set=0, idx_out unchanged; -> IDLE.
REQ-016 Latency: with in_valid held high, start sampled at edge 0 -> set and done high in the cycle after edge 53.
REQ-017 idx_out SHALL change only in COMMIT or on reset; a failed load never disturbs the previous table.
REQ-018 set, done SHALL never be high for two consecutive cycles.

Reset
REQ-019 On reset_n=0: state IDLE; idx_out=0, set=0, done=0, busy=0, in_ready=0, error=0, err_code=00; counter, bitmap, shadow cleared.
REQ-020 Reset mid-LOAD or mid-CHECK SHALL discard the partial table; first start after release begins a fresh load at position 0.

Verification
REQ-021 Load "YRUHQSLDPXNGOKMIEBFZCWVJAT", in_valid constant -> set/done pulse 53 cycles after start, idx_out[207:200]=8'h59, idx_out[7:0]=8'h54, error=0.
REQ-022 Same string with 'a' (8'h61) at position 5 -> done pulse, error=1, err_code=01, no set, idx_out still holds prior table.
REQ-023 Stream beginning "AA" -> reject on 2nd byte, err_code=10, in_ready low next cycle.
REQ-024 Load "BCDEFGHIJKLMNOPQRSTUVWXYZA" -> FAIL at check i=0, err_code=11; load with 'A' at position 0 and otherwise valid pairs -> err_code=11.
REQ-025 Random in_valid gaps during valid load -> identical idx_out to REQ-021; start pulses during LOAD/CHECK ignored.
REQ-026 Assert reset_n=0 after 10 accepted bytes -> all outputs zero immediately; then REQ-021 load completes correctly.
